// File: rtl/apu_frame_sequencer.sv
// NES APU frame sequencer: divides the CPU tick into quarter/half-frame strobes,
// owns the $4017 mode/IRQ-inhibit register and the frame IRQ flag.
module apu_frame_sequencer #(
  parameter int unsigned STEP_TICKS = 7457,
  parameter int unsigned CNT_W      = 16
) (
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic       iTick,
  input  logic       iW4017,
  input  logic [7:0] iData,
  input  logic       iIrq_ack,
  output logic       oEnvelope_clk,
  output logic       oLength_sweep_clk,
  output logic       oFrame_irq,
  output logic       oMode
);

  typedef enum logic [2:0] {StS0, StS1, StS2, StS3, StS4} step_e;

  localparam logic [CNT_W-1:0] DivMax = CNT_W'(STEP_TICKS - 1);

  step_e            step_q, step_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             mode_q, mode_d;
  logic             inhibit_q, inhibit_d;
  logic             irq_q, irq_d;
  logic             env_q, env_d;
  logic             len_q, len_d;

  logic             step_event;
  logic             irq_set;
  logic             unused_data;

  // Only the top two data bits belong to $4017's sequencer fields.
  assign unused_data = ^iData[5:0];

  // A write in the same cycle discards the step event entirely.
  assign step_event = iTick && (div_q == DivMax) && !iW4017;

  // State register
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      step_q    <= StS0;
      div_q     <= '0;
      mode_q    <= 1'b0;
      inhibit_q <= 1'b0;
      irq_q     <= 1'b0;
      env_q     <= 1'b0;
      len_q     <= 1'b0;
    end else begin
      step_q    <= step_d;
      div_q     <= div_d;
      mode_q    <= mode_d;
      inhibit_q <= inhibit_d;
      irq_q     <= irq_d;
      env_q     <= env_d;
      len_q     <= len_d;
    end
  end

  // Next-state: divider, step sequence and $4017 register
  always_comb begin
    div_d     = div_q;
    step_d    = step_q;
    mode_d    = mode_q;
    inhibit_d = inhibit_q;

    if (iW4017) begin
      div_d     = '0;
      step_d    = StS0;
      mode_d    = iData[7];
      inhibit_d = iData[6];
    end else if (iTick) begin
      if (div_q == DivMax) begin
        div_d = '0;
      end else begin
        div_d = div_q + CNT_W'(1);
      end
    end

    if (step_event) begin
      unique case (step_q)
        StS0:    step_d = StS1;
        StS1:    step_d = StS2;
        StS2:    step_d = StS3;
        StS3:    step_d = mode_q ? StS4 : StS0;
        StS4:    step_d = StS0;
        default: step_d = StS0;
      endcase
    end
  end

  // Outputs: strobe and IRQ decode, registered one cycle after the event
  always_comb begin
    env_d   = 1'b0;
    len_d   = 1'b0;
    irq_set = 1'b0;

    if (iW4017) begin
      env_d = iData[7];
      len_d = iData[7];
    end else if (step_event) begin
      unique case (step_q)
        StS0: env_d = 1'b1;
        StS1: begin
          env_d = 1'b1;
          len_d = 1'b1;
        end
        StS2: env_d = 1'b1;
        StS3: begin
          // In 5-step mode S3 is the silent step.
          env_d   = !mode_q;
          len_d   = !mode_q;
          irq_set = !mode_q && !inhibit_q;
        end
        StS4: begin
          env_d = mode_q;
          len_d = mode_q;
        end
        default: begin
          env_d = 1'b0;
          len_d = 1'b0;
        end
      endcase
    end

    // Inhibiting write beats set; set beats acknowledge.
    if (iW4017 && iData[6]) begin
      irq_d = 1'b0;
    end else if (irq_set) begin
      irq_d = 1'b1;
    end else if (iIrq_ack) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  assign oEnvelope_clk     = env_q;
  assign oLength_sweep_clk = len_q;
  assign oFrame_irq        = irq_q;
  assign oMode             = mode_q;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Bench for apu_frame_sequencer: directed vector table, hand-written corner
// sequences, then random stimulus against a tick-count reference model.
module tb_apu_frame_sequencer;

  localparam int unsigned STEP = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, w4017, ack;
  logic [7:0] data;
  logic       env, len, irq, mode;

  int total = 0;
  int bad   = 0;

  apu_frame_sequencer #(
    .STEP_TICKS(STEP),
    .CNT_W     (16)
  ) dut (
    .iClk             (clk),
    .iReset_n         (rst_n),
    .iTick            (tick),
    .iW4017           (w4017),
    .iData            (data),
    .iIrq_ack         (ack),
    .oEnvelope_clk    (env),
    .oLength_sweep_clk(len),
    .oFrame_irq       (irq),
    .oMode            (mode)
  );

  always #5 clk = ~clk;

  // Reference model: ticks since the last restart, sequence picked from tables.
  bit env4 [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
  bit len4 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  bit env5 [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  bit len5 [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  int m_ticks;
  bit m_mode, m_inh, m_irq, m_env, m_len;
  bit chk_model = 1'b0;

  typedef struct {
    bit         t;
    bit         w;
    logic [7:0] d;
    bit         a;
    bit         e_env;
    bit         e_len;
    bit         e_irq;
  } vec_t;
  vec_t vecs [32];

  task automatic check(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ticks = 0;
    m_mode  = 0;
    m_inh   = 0;
    m_irq   = 0;
    m_env   = 0;
    m_len   = 0;
  endtask

  task automatic model_step(bit t, bit w, logic [7:0] d, bit a);
    bit set_irq;
    int k;
    set_irq = 0;
    m_env   = 0;
    m_len   = 0;
    if (w) begin
      m_ticks = 0;
      m_mode  = d[7];
      m_inh   = d[6];
      m_env   = d[7];
      m_len   = d[7];
      if (d[6] || a) m_irq = 0;
    end else begin
      if (t) begin
        m_ticks++;
        if (m_ticks % STEP == 0) begin
          if (m_mode) begin
            k     = (m_ticks / STEP - 1) % 5;
            m_env = env5[k];
            m_len = len5[k];
          end else begin
            k       = (m_ticks / STEP - 1) % 4;
            m_env   = env4[k];
            m_len   = len4[k];
            set_irq = (k == 3) && !m_inh;
          end
        end
      end
      if (set_irq) m_irq = 1;
      else if (a) m_irq = 0;
    end
  endtask

  task automatic cycle(bit t, bit w, logic [7:0] d, bit a);
    tick  = t;
    w4017 = w;
    data  = d;
    ack   = a;
    @(posedge clk);
    #1;
    model_step(t, w, d, a);
    if (chk_model) begin
      check("rnd_env", env, m_env);
      check("rnd_len", len, m_len);
      check("rnd_irq", irq, m_irq);
      check("rnd_mode", mode, m_mode);
    end
  endtask

  // Asynchronous: outputs must clear before any clock edge.
  task automatic apply_reset(string name);
    tick  = 0;
    w4017 = 0;
    data  = 8'h00;
    ack   = 0;
    rst_n = 0;
    #1;
    check({name, "_env"}, env, 1'b0);
    check({name, "_len"}, len, 1'b0);
    check({name, "_irq"}, irq, 1'b0);
    check({name, "_mode"}, mode, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    int first, second, n_env;
    bit prev;

    for (int c = 1; c <= 32; c++) begin
      vecs[c-1].t     = 1;
      vecs[c-1].w     = 0;
      vecs[c-1].d     = 8'h00;
      vecs[c-1].a     = 0;
      vecs[c-1].e_env = (c % 4 == 0);
      vecs[c-1].e_len = (c % 8 == 0);
      vecs[c-1].e_irq = (c >= 16);
    end

    model_reset();
    apply_reset("reset");

    // Test 1: 4-step sequence from the vector table
    foreach (vecs[i]) begin
      cycle(vecs[i].t, vecs[i].w, vecs[i].d, vecs[i].a);
      check("t1_env", env, vecs[i].e_env);
      check("t1_len", len, vecs[i].e_len);
      check("t1_irq", irq, vecs[i].e_irq);
    end

    // Test 2: acknowledge, then inhibit keeps IRQ low for a full pass
    cycle(0, 0, 8'h00, 1);
    check("t2_ack", irq, 1'b0);
    cycle(0, 1, 8'h40, 0);
    check("t2_wr_env", env, 1'b0);
    check("t2_wr_len", len, 1'b0);
    check("t2_wr_mode", mode, 1'b0);
    n_env = 0;
    for (int c = 1; c <= 16; c++) begin
      cycle(1, 0, 8'h00, 0);
      check("t2_irq", irq, 1'b0);
      if (env) n_env++;
    end
    check_int("t2_env_count", n_env, 4);

    // Test 3: 5-step mode, immediate strobes on the write
    cycle(0, 1, 8'h80, 0);
    check("t3_wr_env", env, 1'b1);
    check("t3_wr_len", len, 1'b1);
    check("t3_wr_mode", mode, 1'b1);
    for (int c = 1; c <= 20; c++) begin
      cycle(1, 0, 8'h00, 0);
      check("t3_env", env, (c % 4 == 0) && (c != 16));
      check("t3_len", len, (c == 8) || (c == 20));
      check("t3_irq", irq, 1'b0);
    end

    // Test 4: one tick every three clocks
    cycle(0, 1, 8'h00, 0);
    first  = -1;
    second = -1;
    prev   = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(i % 3 == 0, 0, 8'h00, 0);
      if (prev) check("t4_width", env, 1'b0);
      if (env) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      prev = env;
    end
    check_int("t4_first", first, 9);
    check_int("t4_period", second - first, 12);

    // Test 5: write collides with the IRQ-setting step event
    cycle(0, 1, 8'h00, 0);
    check("t5_irq_pre", irq, 1'b0);
    for (int c = 1; c <= 15; c++) cycle(1, 0, 8'h00, 0);
    cycle(1, 1, 8'h00, 0);
    check("t5_env", env, 1'b0);
    check("t5_len", len, 1'b0);
    check("t5_irq", irq, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      cycle(1, 0, 8'h00, 0);
      check("t5_after_env", env, c == 4);
    end

    // Test 6: reset while a strobe is high at S2 in 5-step mode
    cycle(0, 1, 8'h80, 0);
    for (int c = 1; c <= 8; c++) cycle(1, 0, 8'h00, 0);
    check("t6_pre_env", env, 1'b1);
    apply_reset("t6_rst");
    for (int c = 1; c <= 4; c++) begin
      cycle(1, 0, 8'h00, 0);
      check("t6_env", env, c == 4);
      check("t6_mode", mode, 1'b0);
    end

    // Random stimulus against the reference model
    apply_reset("rnd_rst");
    chk_model = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        apply_reset("rnd_mid_rst");
      end
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 8'($urandom),
            $urandom_range(0, 15) == 0);
    end
    chk_model = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
